mips_multi_cycle_control: RTL
=============================

Name: mips_multi_cycle_control

Overview:
- Next-generation control unit for the MIPS core: a multi-cycle FSM that replaces single-cycle combinational decode.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over a shared datapath.
- Talks to variable-latency memory through a req/ack handshake, with timeout.
- Raises sticky traps and keeps saturating instruction/stall counters.

Parameters:
MEM_TIMEOUT, 16, max cycles req may stay high without ack before a timeout trap (legal range 2..255)
CNT_W, 16, width of performance counters

Ports:
i_clk  in  1  clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_op_code  in  6  instruction register bits [31:26]
i_zero  in  1  ALU zero flag, valid in BRANCH state
i_mem_ack  in  1  memory completion, sampled while o_mem_req=1
o_mem_req  out  1  memory request
o_mem_write  out  1  1=store, 0=load/fetch
o_iord  out  1  address mux: 0=PC, 1=ALU result
o_ir_load  out  1  latch fetched word into IR
o_pc_write  out  1  PC update strobe
o_pc_src  out  2  00=PC+4, 01=branch target, 10=jump target
o_alu_src_a  out  1  0=PC, 1=rs
o_alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=zero-ext imm
o_alu_ctrl  out  4  0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 0111 SLT, 1111 use funct
o_reg_dst  out  1  1=rd, 0=rt
o_mem_to_reg  out  1  write-back select
o_w_en  out  1  register file write
o_trap  out  1  sticky trap flag
o_trap_cause  out  2  01 illegal opcode, 10 memory timeout
o_instr_count  out  CNT_W  retired instructions, saturating
o_stall_count  out  CNT_W  cycles with req=1 and ack=0, saturating

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP.
- Reset (i_reset=0, async): state=FETCH. trap, cause, both counters and timeout counter cleared. All strobes are 0 except o_mem_req, which is 1 once reset deasserts.
- Reset mid-operation aborts immediately; there is no partial write-back.
- FETCH:
  - o_mem_req=1, o_iord=0, o_mem_write=0.
  - On ack: o_ir_load=1, o_pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, ADD; go to DECODE.
- DECODE, one cycle:
  - Opcodes: 000000 R -> EXEC; 100011 lw / 101011 sw / 001000 addi / 001100 andi / 001101 ori / 001010 slti -> EXEC; 000100 beq / 000101 bne -> BRANCH; 000010 j -> JUMP.
  - Any other opcode -> TRAP, cause 01.
- EXEC:
  - alu_src_a=1.
  - R-type: src_b=00, ctrl=1111.
  - lw/sw/addi: src_b=10, ADD.
  - slti: src_b=10, SLT.
  - andi: src_b=11, AND.
  - ori: src_b=11, OR.
  - lw/sw -> MEM; all others -> WB.
- MEM:
  - o_mem_req=1, o_iord=1, o_mem_write=1 for sw only.
  - On ack: sw retires and goes to FETCH; lw goes to WB.
- WB:
  - o_w_en=1 for one cycle.
  - reg_dst=1 for R-type, else 0.
  - mem_to_reg=1 for lw only.
  - Retire, then go to FETCH.
- BRANCH:
  - src_a=1, src_b=00, SUB.
  - o_pc_write = (beq & i_zero) | (bne & ~i_zero), with pc_src=01.
  - Retire, then go to FETCH.
- JUMP: o_pc_write=1, pc_src=10; retire; go to FETCH.
- Latency with zero-wait memory (ack in the first req cycle): R/addi/logic/slti 4 cycles, lw 5, sw 4, beq/bne/j 3.
- Each wait cycle adds 1.
- Timeout:
  - The counter increments each cycle with req=1 and ack=0, and clears on ack or on a state change.
  - When the counter equals MEM_TIMEOUT-1 with ack still 0 -> TRAP, cause 10.
  - An ack in that same cycle wins; no trap.
- TRAP:
  - All strobes 0, o_mem_req=0, o_trap=1.
  - Exit only by reset.
  - The first cause recorded is held.
- Counters:
  - o_instr_count increments on the retire cycle; o_stall_count increments per stall cycle.
  - Both saturate at all-ones with no wrap.
  - Both freeze in TRAP.
- o_w_en, o_pc_write and o_ir_load never assert outside the states listed above.

Test Plan:
- Reset released, ack tied 1, opcode 000000 -> state sequence FETCH, DECODE, EXEC, WB, FETCH. o_w_en pulses once with reg_dst=1, ctrl=1111. o_instr_count=1 after 4 cycles.
- lw (100011) with ack delayed 3 cycles in MEM -> 8 cycles total. mem_to_reg=1 and w_en=1 in WB. o_stall_count=3.
- beq with i_zero=1 -> pc_write=1, pc_src=01 in BRANCH. bne with i_zero=1 -> pc_write=0. Each takes 3 cycles.
- Opcode 111111 -> TRAP after DECODE, o_trap=1, cause=01. Counters and outputs frozen for 20 cycles until i_reset=0.
- MEM_TIMEOUT=4, ack held 0 in FETCH -> TRAP on the 4th req cycle, cause=10. Repeat with ack arriving on the 4th cycle -> no trap, DECODE follows.
- CNT_W=4, 20 j instructions -> o_instr_count saturates at 15. Asserting i_reset=0 mid-EXEC -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/mips_multi_cycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared datapath, with a req/ack memory handshake, timeout trap and saturating counters.
module mips_multi_cycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [5:0]       i_op_code,
    input  logic             i_zero,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_mem_write,
    output logic             o_iord,
    output logic             o_ir_load,
    output logic             o_pc_write,
    output logic [1:0]       o_pc_src,
    output logic             o_alu_src_a,
    output logic [1:0]       o_alu_src_b,
    output logic [3:0]       o_alu_ctrl,
    output logic             o_reg_dst,
    output logic             o_mem_to_reg,
    output logic             o_w_en,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_instr_count,
    output logic [CNT_W-1:0] o_stall_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_FUNCT = 4'b1111;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        FETCH, DECODE, EXEC, MEM, WB, BRANCH, JUMP, TRAP
    } state_t;

    state_t           state, next_state;
    logic [5:0]       op_q;
    logic [7:0]       tmo_cnt;
    logic             trap;
    logic [1:0]       cause;
    logic [CNT_W-1:0] instr_count, stall_count;

    logic       req, stall, tmo_hit, retire, trap_set;
    logic [1:0] trap_cause_nxt;

    assign req     = (state == FETCH) || (state == MEM);
    assign stall   = req && !i_mem_ack;
    assign tmo_hit = stall && (tmo_cnt == TMO_LAST);

    always_comb begin
        next_state     = state;
        retire         = 1'b0;
        trap_set       = 1'b0;
        trap_cause_nxt = 2'b00;
        o_mem_req      = 1'b0;
        o_mem_write    = 1'b0;
        o_iord         = 1'b0;
        o_ir_load      = 1'b0;
        o_pc_write     = 1'b0;
        o_pc_src       = 2'b00;
        o_alu_src_a    = 1'b0;
        o_alu_src_b    = 2'b00;
        o_alu_ctrl     = 4'b0000;
        o_reg_dst      = 1'b0;
        o_mem_to_reg   = 1'b0;
        o_w_en         = 1'b0;
        case (state)
            FETCH: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    o_ir_load   = 1'b1;
                    o_pc_write  = 1'b1;
                    o_alu_src_b = 2'b01;
                    o_alu_ctrl  = ALU_ADD;
                    next_state  = DECODE;
                end else if (tmo_hit) begin
                    next_state     = TRAP;
                    trap_set       = 1'b1;
                    trap_cause_nxt = 2'b10;
                end
            end
            DECODE: begin
                case (i_op_code)
                    OP_R, OP_LW, OP_SW, OP_ADDI,
                    OP_ANDI, OP_ORI, OP_SLTI: next_state = EXEC;
                    OP_BEQ, OP_BNE:           next_state = BRANCH;
                    OP_J:                     next_state = JUMP;
                    default: begin
                        next_state     = TRAP;
                        trap_set       = 1'b1;
                        trap_cause_nxt = 2'b01;
                    end
                endcase
            end
            EXEC: begin
                o_alu_src_a = 1'b1;
                case (op_q)
                    OP_R:                 begin o_alu_src_b = 2'b00; o_alu_ctrl = ALU_FUNCT; end
                    OP_LW, OP_SW, OP_ADDI: begin o_alu_src_b = 2'b10; o_alu_ctrl = ALU_ADD; end
                    OP_SLTI:              begin o_alu_src_b = 2'b10; o_alu_ctrl = ALU_SLT; end
                    OP_ANDI:              begin o_alu_src_b = 2'b11; o_alu_ctrl = ALU_AND; end
                    OP_ORI:               begin o_alu_src_b = 2'b11; o_alu_ctrl = ALU_OR; end
                    default: ;
                endcase
                next_state = (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
            end
            MEM: begin
                o_mem_req   = 1'b1;
                o_iord      = 1'b1;
                o_mem_write = (op_q == OP_SW);
                if (i_mem_ack) begin
                    // a store completes here; a load still needs its write-back cycle
                    retire     = (op_q == OP_SW);
                    next_state = (op_q == OP_SW) ? FETCH : WB;
                end else if (tmo_hit) begin
                    next_state     = TRAP;
                    trap_set       = 1'b1;
                    trap_cause_nxt = 2'b10;
                end
            end
            WB: begin
                o_w_en       = 1'b1;
                o_reg_dst    = (op_q == OP_R);
                o_mem_to_reg = (op_q == OP_LW);
                retire       = 1'b1;
                next_state   = FETCH;
            end
            BRANCH: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b00;
                o_alu_ctrl  = ALU_SUB;
                o_pc_src    = 2'b01;
                o_pc_write  = ((op_q == OP_BEQ) && i_zero) || ((op_q == OP_BNE) && !i_zero);
                retire      = 1'b1;
                next_state  = FETCH;
            end
            JUMP: begin
                o_pc_write = 1'b1;
                o_pc_src   = 2'b10;
                retire     = 1'b1;
                next_state = FETCH;
            end
            TRAP: ;
            default: next_state = FETCH;
        endcase
        // Reset forces every strobe low immediately, without waiting for a clock edge.
        if (!i_reset) begin
            o_mem_req    = 1'b0;
            o_mem_write  = 1'b0;
            o_iord       = 1'b0;
            o_ir_load    = 1'b0;
            o_pc_write   = 1'b0;
            o_pc_src     = 2'b00;
            o_alu_src_a  = 1'b0;
            o_alu_src_b  = 2'b00;
            o_alu_ctrl   = 4'b0000;
            o_reg_dst    = 1'b0;
            o_mem_to_reg = 1'b0;
            o_w_en       = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= FETCH;
            op_q        <= 6'b000000;
            tmo_cnt     <= 8'd0;
            trap        <= 1'b0;
            cause       <= 2'b00;
            instr_count <= '0;
            stall_count <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE)
                op_q <= i_op_code;
            if (i_mem_ack || (next_state != state))
                tmo_cnt <= 8'd0;
            else if (stall)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (trap_set && !trap) begin
                trap  <= 1'b1;
                cause <= trap_cause_nxt;
            end
            if (retire && (instr_count != '1))
                instr_count <= instr_count + CNT_W'(1);
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    assign o_trap        = trap;
    assign o_trap_cause  = cause;
    assign o_instr_count = instr_count;
    assign o_stall_count = stall_count;

endmodule
